// File: rtl/mips_cpu_lsu_pkg.sv
// mips_cpu_lsu_pkg: shared op codes, FSM states, lane constants and decode helpers for the LSU.
// LWL/LWR become legal only when MIPS_CPU_LSU_LWLR_EN is defined.
package mips_cpu_lsu_pkg;

    typedef enum logic [3:0] {
        LW  = 4'd0,
        LB  = 4'd1,
        LBU = 4'd2,
        LH  = 4'd3,
        LHU = 4'd4,
        SW  = 4'd5,
        SB  = 4'd6,
        SH  = 4'd7,
        LWL = 4'd8,
        LWR = 4'd9
    } lsu_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDATA  = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    function automatic logic op_legal(input lsu_op_t op, input logic [1:0] b);
        case (op)
            LW, SW:       return b == 2'b00;
            LH, LHU, SH:  return !b[0];
            LB, LBU, SB:  return 1'b1;
`ifdef MIPS_CPU_LSU_LWLR_EN
            LWL, LWR:     return 1'b1;
`endif
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic op_store(input lsu_op_t op);
        return op inside {SW, SB, SH};
    endfunction

    function automatic logic [3:0] lane_enable(input lsu_op_t op, input logic [1:0] b);
        return (op inside {LB, LBU, SB}) ? BE_BYTE0 << b :
               (op inside {LH, LHU, SH}) ? (b[1] ? BE_HALF1 : BE_HALF0) : BE_WORD;
    endfunction

    function automatic logic [31:0] store_data(input lsu_op_t op, input logic [31:0] wd);
        return (op == SB) ? {4{wd[7:0]}} : (op == SH) ? {2{wd[15:0]}} : wd;
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_format.sv
// mips_cpu_lsu_format: byte/half selection with sign/zero extension of load data;
// LWL/LWR merge with the old rt value when MIPS_CPU_LSU_LWLR_EN is defined.
module mips_cpu_lsu_format
    import mips_cpu_lsu_pkg::*;
(
    input  lsu_op_t     op_i,
    input  logic [1:0]  b_i,
    input  logic [31:0] readdata_i,
    input  logic [31:0] rt_old_i,
    output logic [31:0] resp_data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = readdata_i >> {b_i, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = b_i[1] ? readdata_i[31:16] : readdata_i[15:0];

`ifndef MIPS_CPU_LSU_LWLR_EN
    logic unused_rt_old;
    assign unused_rt_old = ^rt_old_i;
`endif

    always_comb begin
        resp_data_o = '0;
        case (op_i)
            LW:  resp_data_o = readdata_i;
            LB:  resp_data_o = {{24{byte_sel[7]}}, byte_sel};
            LBU: resp_data_o = {24'h0, byte_sel};
            LH:  resp_data_o = {{16{half_sel[15]}}, half_sel};
            LHU: resp_data_o = {16'h0, half_sel};
`ifdef MIPS_CPU_LSU_LWLR_EN
            // LWL shifts by 8*(3-b); for a 2-bit b, 3-b is simply ~b
            LWL: resp_data_o = (readdata_i << {~b_i, 3'b000})
                             | (rt_old_i & ((32'h1 << {~b_i, 3'b000}) - 32'h1));
            LWR: resp_data_o = shifted | (rt_old_i & ~(32'hFFFF_FFFF >> {b_i, 3'b000}));
`endif
            default: resp_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu: single-outstanding load/store unit bridging the CPU memory stage to an Avalon-MM master.
// Optional LWL/LWR support via MIPS_CPU_LSU_LWLR_EN.
module mips_cpu_lsu
    import mips_cpu_lsu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    lsu_state_t  state_q;
    lsu_op_t     op_q;
    logic [1:0]  b_q;
    logic [31:0] rt_old_q;
    logic [31:0] fmt_data;
    lsu_op_t     op_in;
    logic        legal;
    logic        store;

    assign op_in = lsu_op_t'(req_op);
    assign legal = op_legal(op_in, req_addr[1:0]);
    assign store = op_store(op_in);

    mips_cpu_lsu_format u_format (
        .op_i        (op_q),
        .b_i         (b_q),
        .readdata_i  (readdata),
        .rt_old_i    (rt_old_q),
        .resp_data_o (fmt_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= LW;
            b_q        <= 2'b00;
            rt_old_q   <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_data  <= '0;
            address    <= RESET_ADDR;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q       <= op_in;
                    b_q        <= req_addr[1:0];
                    rt_old_q   <= req_rt_old;
                    req_ready  <= 1'b0;
                    resp_data  <= '0;
                    resp_error <= !legal;
                    if (legal) begin
                        state_q    <= S_ACCESS;
                        address    <= {req_addr[31:2], 2'b00};
                        read       <= !store;
                        write      <= store;
                        byteenable <= lane_enable(op_in, req_addr[1:0]);
                        writedata  <= store ? store_data(op_in, req_wdata) : '0;
                    end else begin
                        // illegal requests answer immediately without touching the bus
                        state_q    <= S_RESP;
                        resp_valid <= 1'b1;
                    end
                end
                S_ACCESS: if (!waitrequest) begin
                    state_q    <= read ? S_RDATA : S_RESP;
                    resp_valid <= !read;
                    read       <= 1'b0;
                    write      <= 1'b0;
                    address    <= RESET_ADDR;
                    byteenable <= '0;
                    writedata  <= '0;
                end
                S_RDATA: begin
                    state_q    <= S_RESP;
                    resp_data  <= fmt_data;
                    resp_valid <= 1'b1;
                end
                S_RESP: begin
                    state_q    <= S_IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb_mips_cpu_lsu: directed self-checking bench for mips_cpu_lsu with hand-computed expectations.
module tb_mips_cpu_lsu;
    import mips_cpu_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt_old;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int n_cmp = 0;
    int n_err = 0;

    mips_cpu_lsu dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rt_old  (req_rt_old),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_error  (resp_error),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rt_old);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wd;
        req_rt_old = rt_old;
        tick();
        req_valid  = 1'b0;
        req_wdata  = 32'h5555_5555;
        req_rt_old = 32'h6666_6666;
    endtask

    task automatic do_error(input string tag, input lsu_op_t op, input logic [31:0] addr);
        issue(op, addr, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, " resp_error"}, {31'h0, resp_error}, 32'h1);
        chk({tag, " resp_data"}, resp_data, 32'h0);
        chk({tag, " no bus"}, {30'h0, read, write}, 32'h0);
        tick();
        chk({tag, " resp_done"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, " bus idle"}, {30'h0, read, write}, 32'h0);
    endtask

    task automatic do_store(input string tag, input lsu_op_t op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        waitrequest = 1'b0;
        issue(op, addr, wd, 32'h0);
        chk({tag, " write"}, {31'h0, write}, 32'h1);
        chk({tag, " read"}, {31'h0, read}, 32'h0);
        chk({tag, " address"}, address, exp_addr);
        chk({tag, " be"}, {28'h0, byteenable}, {28'h0, exp_be});
        chk({tag, " writedata"}, writedata, exp_wd);
        chk({tag, " early resp"}, {31'h0, resp_valid}, 32'h0);
        tick();
        chk({tag, " write drop"}, {31'h0, write}, 32'h0);
        chk({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, " resp_error"}, {31'h0, resp_error}, 32'h0);
        chk({tag, " resp_data"}, resp_data, 32'h0);
        tick();
        chk({tag, " resp_done"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic do_load(input string tag, input lsu_op_t op, input logic [31:0] addr,
                           input logic [31:0] rt_old, input logic [31:0] rd,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
        waitrequest = 1'b0;
        readdata    = 32'h0BAD_0BAD;
        issue(op, addr, 32'h0, rt_old);
        chk({tag, " read"}, {31'h0, read}, 32'h1);
        chk({tag, " write"}, {31'h0, write}, 32'h0);
        chk({tag, " address"}, address, exp_addr);
        chk({tag, " be"}, {28'h0, byteenable}, {28'h0, exp_be});
        tick();
        chk({tag, " read drop"}, {31'h0, read}, 32'h0);
        chk({tag, " early resp"}, {31'h0, resp_valid}, 32'h0);
        readdata = rd;
        tick();
        readdata = 32'h0BAD_0BAD;
        chk({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, " resp_error"}, {31'h0, resp_error}, 32'h0);
        chk({tag, " resp_data"}, resp_data, exp_data);
        tick();
        chk({tag, " resp_done"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_op      = 4'd0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_rt_old  = 32'h0;
        waitrequest = 1'b0;
        readdata    = 32'h0;
        tick();
        tick();
        chk("rst ready", {31'h0, req_ready}, 32'h1);
        chk("rst bus", {30'h0, read, write}, 32'h0);
        chk("rst address", address, 32'h0);
        chk("rst be", {28'h0, byteenable}, 32'h0);
        chk("rst writedata", writedata, 32'h0);
        chk("rst resp", {30'h0, resp_valid, resp_error}, 32'h0);
        chk("rst resp_data", resp_data, 32'h0);
        reset = 1'b0;
        tick();

        do_store("SW", SW, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF);
        do_store("SH", SH, 32'h0000_0006, 32'h1234_ABCD, 32'h0000_0004, 4'b1100, 32'hABCD_ABCD);
        do_store("SB", SB, 32'h0000_0003, 32'h0000_015A, 32'h0000_0000, 4'b1000, 32'h5A5A_5A5A);
        do_store("SB1", SB, 32'h8000_3001, 32'hFFFF_FF3C, 32'h8000_3000, 4'b0010, 32'h3C3C_3C3C);

        // LB with three wait states: read is held four cycles
        waitrequest = 1'b1;
        readdata    = 32'h0BAD_0BAD;
        issue(LB, 32'h0000_2003, 32'h0, 32'h0);
        chk("LBw address", address, 32'h0000_2000);
        chk("LBw be", {28'h0, byteenable}, 32'h8);
        for (int i = 0; i < 3; i++) begin
            chk("LBw read", {31'h0, read}, 32'h1);
            chk("LBw stable addr", address, 32'h0000_2000);
            tick();
        end
        chk("LBw read4", {31'h0, read}, 32'h1);
        waitrequest = 1'b0;
        tick();
        chk("LBw read drop", {31'h0, read}, 32'h0);
        readdata = 32'h80FF_7F01;
        tick();
        chk("LBw resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("LBw resp_data", resp_data, 32'hFFFF_FF80);
        tick();
        chk("LBw resp_done", {31'h0, resp_valid}, 32'h0);

        do_load("LBU", LBU, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 32'h0000_2000, 4'b1000, 32'h0000_0080);
        do_load("LB1", LB, 32'h0000_2001, 32'h0, 32'h80FF_7F01, 32'h0000_2000, 4'b0010, 32'h0000_007F);
        do_load("LB0", LB, 32'h0000_2000, 32'h0, 32'h80FF_7F81, 32'h0000_2000, 4'b0001, 32'hFFFF_FF81);
        do_load("LH", LH, 32'h0000_0006, 32'h0, 32'h8001_FFFF, 32'h0000_0004, 4'b1100, 32'hFFFF_8001);
        do_load("LHU", LHU, 32'h0000_0006, 32'h0, 32'h8001_FFFF, 32'h0000_0004, 4'b1100, 32'h0000_8001);
        do_load("LH0", LH, 32'h0000_0000, 32'h0, 32'h8001_7FFE, 32'h0000_0000, 4'b0011, 32'h0000_7FFE);
        do_load("LW", LW, 32'hFFFF_FFFC, 32'h0, 32'h1234_5678, 32'hFFFF_FFFC, 4'b1111, 32'h1234_5678);

        do_error("LW mis", LW, 32'h0000_0002);
        do_error("SW mis", SW, 32'h0000_0001);
        do_error("LH mis", LH, 32'h0000_0003);
        do_error("SH mis", SH, 32'h0000_0005);
        do_error("op 15", lsu_op_t'(4'd15), 32'h0000_0000);

        // reset while stalled abandons the transaction silently
        waitrequest = 1'b1;
        issue(LW, 32'h0000_0010, 32'h0, 32'h0);
        chk("abort read", {31'h0, read}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort read drop", {31'h0, read}, 32'h0);
        chk("abort ready", {31'h0, req_ready}, 32'h1);
        chk("abort resp", {31'h0, resp_valid}, 32'h0);
        waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort quiet", {29'h0, resp_valid, read, write}, 32'h0);
        end
        do_load("LW10", LW, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D);

`ifdef MIPS_CPU_LSU_LWLR_EN
        do_load("LWL", LWL, 32'h0000_0001, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_0000, 4'b1111, 32'h2211_CCDD);
        do_load("LWR", LWR, 32'h0000_0001, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_0000, 4'b1111, 32'hAA44_3322);
        do_load("LWL3", LWL, 32'h0000_0003, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_0000, 4'b1111, 32'h4433_2211);
        do_load("LWR0", LWR, 32'h0000_0000, 32'hAABB_CCDD, 32'h4433_2211, 32'h0000_0000, 4'b1111, 32'h4433_2211);
`else
        do_error("LWL off", LWL, 32'h0000_0001);
        do_error("LWR off", LWR, 32'h0000_0001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
